// File: rtl/mul_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier.
// FSM state encoding, Booth selector one-hot codes, default operand width
// and the triplet decode helper.
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [4:0] booth_sel_t;

    localparam booth_sel_t ZERO = 5'b00001;
    localparam booth_sel_t POS1 = 5'b00010;
    localparam booth_sel_t NEG1 = 5'b00100;
    localparam booth_sel_t POS2 = 5'b01000;
    localparam booth_sel_t NEG2 = 5'b10000;

    // Map a Booth triplet {y[i+1], y[i], y[i-1]} to a one-hot select.
    function automatic booth_sel_t booth_decode(input logic [2:0] y);
        booth_sel_t sel;
        case (y)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_seq_mul_if.sv
// Operand / product handshake bundle for booth_r4_seq_mul.
// master = issuing/writeback side, slave = the multiplier.
interface booth_r4_seq_mul_if #(
    parameter int WIDTH = mul_pkg::MUL_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 cancel;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport master (
        output in_valid, in_a, in_b, cancel, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, cancel, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector.
// Produces a 2*WIDTH partial product and a +1 carry; negative selections
// return the one's complement so the +1 is folded into the accumulator add.
module booth_r4_sel
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [2:0]         trip_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    output logic [2*WIDTH-1:0] pp_o,
    output logic               carry_o
);

    booth_sel_t sel;

    assign sel = booth_decode(trip_i);

    // Select multiple of the multiplicand for this triplet.
    always_comb begin
        pp_o    = '0;
        carry_o = 1'b0;
        case (sel)
            POS1: pp_o = mcand_i;
            POS2: pp_o = {mcand_i[2*WIDTH-2:0], 1'b0};
            NEG1: begin
                pp_o    = ~mcand_i;
                carry_o = 1'b1;
            end
            NEG2: begin
                pp_o    = ~{mcand_i[2*WIDTH-2:0], 1'b0};
                carry_o = 1'b1;
            end
            default: begin
                pp_o    = '0;
                carry_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative signed radix-4 Booth multiplier, one Booth digit per cycle.
// Optional macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all equal (every later digit would be zero).
//
// state | meaning
// IDLE  | ready for operands
// BUSY  | accumulating one Booth partial product per cycle
// DONE  | product held on out_p until accepted or cancelled
module booth_r4_seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input logic                clk,
    input logic                rst,
    booth_r4_seq_mul_if.slave  bus
);

    localparam int ITER  = WIDTH / 2;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH:0]   mplr_q, mplr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PW-1:0]    pp;
    logic             pp_carry;
    logic [WIDTH:0]   mplr_shr;
    logic             last_iter;

    booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
        .trip_i  (mplr_q[2:0]),
        .mcand_i (mcand_q),
        .pp_o    (pp),
        .carry_o (pp_carry)
    );

    assign mplr_shr = {{2{mplr_q[WIDTH]}}, mplr_q[WIDTH:2]};

`ifdef BOOTH_EARLY_TERM_EN
    // Once the shifted multiplier is all 0s or all 1s, no further digit contributes.
    assign last_iter = (cnt_q == CNT_LAST) || (&mplr_shr) || ~(|mplr_shr);
`else
    assign last_iter = (cnt_q == CNT_LAST);
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplr_d        = mplr_q;
        cnt_d         = cnt_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_p     = '0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    mcand_d = {{WIDTH{bus.in_a[WIDTH-1]}}, bus.in_a};
                    mplr_d  = {bus.in_b, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = acc_q + pp + {{(PW-1){1'b0}}, pp_carry};
                mcand_d = {mcand_q[PW-3:0], 2'b00};
                mplr_d  = mplr_shr;
                cnt_d   = cnt_q + 1'b1;
                if (bus.cancel) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_p = acc_q;
                // A cancel in this cycle must not be seen as a delivered product.
                bus.out_valid = ~bus.cancel;
                if (bus.cancel || bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
